// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-style control FSM with wait-state stretching of memory phases.
// Optional exception path (EXC state, EPC capture) enabled by MC_CTRL_EXCEPTION_EN.
module mc_control_fsm #(
  parameter int WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [5:0] opcode,
  input  logic       overflow,
  input  logic       alu_undefined_instr,
  output logic       pc_write,
  output logic       pc_write_cond_eq,
  output logic       pc_write_cond_ne,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       write_epc,
  output logic       undefined_instr,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;
  localparam logic [3:0] S_EXC       = 4'd12;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [2:0] WMAX = 3'(WAIT_STATES);

  logic [3:0] nxt;
  logic [2:0] wcnt;
  logic       wait_st;
  logic       wait_done;
  logic       live;
  logic       pw_r, ceq_r, cne_r, irw_r, rw_r, mw_r, epc_r;

`ifdef MC_CTRL_EXCEPTION_EN
  logic exc_und;
  logic exc_und_d;
`else
  logic unused_exc_inputs;
  assign unused_exc_inputs = ^{overflow, alu_undefined_instr};
`endif

  assign wait_st   = (state == S_FETCH) || (state == S_MEM_READ) ||
                     (state == S_MEM_WRITE);
  assign wait_done = !wait_st || (wcnt == WMAX);
  assign live      = enable & ~reset;

  always_comb begin
    nxt = state;
`ifdef MC_CTRL_EXCEPTION_EN
    exc_und_d = exc_und;
`endif
    case (state)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):   nxt = S_MEM_ADDR;
          (opcode == OP_R):    nxt = S_R_EXEC;
          (opcode == OP_BEQ),
          (opcode == OP_BNE):  nxt = S_BRANCH;
          (opcode == OP_J):    nxt = S_JUMP;
          (opcode == OP_ADDI): nxt = S_ADDI_EXEC;
          default: begin
`ifdef MC_CTRL_EXCEPTION_EN
            nxt       = S_EXC;
            exc_und_d = 1'b1;
`else
            nxt = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM_ADDR:  nxt = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  nxt = S_MEM_WB;
      S_MEM_WB:    nxt = S_FETCH;
      S_MEM_WRITE: nxt = S_FETCH;
      S_R_EXEC: begin
        nxt = S_R_WB;
`ifdef MC_CTRL_EXCEPTION_EN
        if (alu_undefined_instr || overflow) begin
          nxt       = S_EXC;
          exc_und_d = alu_undefined_instr;
        end
`endif
      end
      S_R_WB:      nxt = S_FETCH;
      S_BRANCH:    nxt = S_FETCH;
      S_JUMP:      nxt = S_FETCH;
      S_ADDI_EXEC: begin
        nxt = S_ADDI_WB;
`ifdef MC_CTRL_EXCEPTION_EN
        if (overflow) begin
          nxt       = S_EXC;
          exc_und_d = 1'b0;
        end
`endif
      end
      S_ADDI_WB:   nxt = S_FETCH;
      default:     nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      wcnt  <= 3'd0;
`ifdef MC_CTRL_EXCEPTION_EN
      exc_und <= 1'b0;
`endif
    end else if (enable) begin
      if (!wait_done) begin
        wcnt <= wcnt + 3'd1;
      end else begin
        wcnt  <= 3'd0;
        state <= nxt;
`ifdef MC_CTRL_EXCEPTION_EN
        exc_und <= exc_und_d;
`endif
      end
    end
  end

  always_comb begin
    pw_r            = 1'b0;
    ceq_r           = 1'b0;
    cne_r           = 1'b0;
    irw_r           = 1'b0;
    rw_r            = 1'b0;
    mw_r            = 1'b0;
    epc_r           = 1'b0;
    iord            = 1'b0;
    mem_read        = 1'b0;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    alu_op          = 2'b00;
    pc_source       = 2'b00;
    undefined_instr = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        irw_r     = wait_done;
        pw_r      = wait_done;
      end
      S_DECODE:    alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        rw_r       = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mw_r = 1'b1;
        iord = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        rw_r    = 1'b1;
        reg_dst = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        ceq_r     = (opcode == OP_BEQ);
        cne_r     = (opcode == OP_BNE);
      end
      S_JUMP: begin
        pw_r      = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB:   rw_r = 1'b1;
`ifdef MC_CTRL_EXCEPTION_EN
      S_EXC: begin
        epc_r           = 1'b1;
        pw_r            = 1'b1;
        pc_source       = 2'b11;
        undefined_instr = exc_und;
      end
`endif
      default: ;
    endcase
  end

  // Write strobes die while frozen or in reset so no side effect leaks out.
  assign pc_write         = pw_r  & live;
  assign pc_write_cond_eq = ceq_r & live;
  assign pc_write_cond_ne = cne_r & live;
  assign ir_write         = irw_r & live;
  assign reg_write        = rw_r  & live;
  assign mem_write        = mw_r  & live;
  assign write_epc        = epc_r & live;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: two instances (0 and 2 wait states) checked
// cycle by cycle against a per-instruction state-sequence model.
module tb_mc_control_fsm;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;

`ifdef MC_CTRL_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  typedef struct {
    int st;
    bit last;
    bit und;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        en  [2];
  logic        ovf [2];
  logic        aund[2];
  logic [5:0]  op  [2];
  logic [18:0] ov  [2];
  logic [3:0]  st  [2];

  int total = 0;
  int bad   = 0;
  step_t q[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic pw, ceq, cne, irw, iord, mr, mw, rw, rd, m2r, sa, epc, und;
    logic [1:0] sb, aop, ps;
    mc_control_fsm #(.WAIT_STATES(g * 2)) u_dut (
      .clk                 (clk),
      .reset               (rst[g]),
      .enable              (en[g]),
      .opcode              (op[g]),
      .overflow            (ovf[g]),
      .alu_undefined_instr (aund[g]),
      .pc_write            (pw),
      .pc_write_cond_eq    (ceq),
      .pc_write_cond_ne    (cne),
      .ir_write            (irw),
      .iord                (iord),
      .mem_read            (mr),
      .mem_write           (mw),
      .reg_write           (rw),
      .reg_dst             (rd),
      .mem_to_reg          (m2r),
      .alu_src_a           (sa),
      .alu_src_b           (sb),
      .alu_op              (aop),
      .pc_source           (ps),
      .write_epc           (epc),
      .undefined_instr     (und),
      .state               (st[g])
    );
    assign ov[g] = {pw, ceq, cne, irw, iord, mr, mw, rw, rd, m2r,
                    sa, sb, aop, ps, epc, und};
  end

  function automatic logic [18:0] exp_vec(step_t s, logic [5:0] o,
                                          bit e, bit r);
    logic pw, ceq, cne, irw, iord, mr, mw, rw, rd, m2r, sa, epc, und;
    logic [1:0] sb, aop, ps;
    {pw, ceq, cne, irw, iord, mr, mw, rw, rd, m2r, sa, epc, und} = '0;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (s.st)
      0:  begin mr = 1; sb = 2'b01; irw = s.last; pw = s.last; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; aop = 2'b01; ps = 2'b01;
                ceq = (o == BEQ); cne = (o == BNE); end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      12: begin epc = 1; pw = 1; ps = 2'b11; und = s.und; end
      default: ;
    endcase
    if (!e || r) {pw, ceq, cne, irw, rw, mw, epc} = '0;
    return {pw, ceq, cne, irw, iord, mr, mw, rw, rd, m2r,
            sa, sb, aop, ps, epc, und};
  endfunction

  task automatic push(input int s, input bit l, input bit u);
    step_t x;
    x.st = s; x.last = l; x.und = u;
    q.push_back(x);
  endtask

  // Expected sequence of states for one whole instruction.
  task automatic build(input int d, input logic [5:0] o,
                       input bit v, input bit a);
    int ws = d * 2;
    for (int i = 0; i <= ws; i++) push(0, i == ws, 0);
    push(1, 0, 0);
    case (o)
      LW: begin
        push(2, 0, 0);
        for (int i = 0; i <= ws; i++) push(3, 0, 0);
        push(4, 0, 0);
      end
      SW: begin
        push(2, 0, 0);
        for (int i = 0; i <= ws; i++) push(5, 0, 0);
      end
      RT: begin
        push(6, 0, 0);
        if (EXC_EN && (a || v)) push(12, 0, a);
        else push(7, 0, 0);
      end
      BEQ, BNE: push(8, 0, 0);
      JMP: push(9, 0, 0);
      ADDI: begin
        push(10, 0, 0);
        if (EXC_EN && v) push(12, 0, 0);
        else push(11, 0, 0);
      end
      default: if (EXC_EN) push(12, 0, 1);
    endcase
  endtask

  task automatic check(input int d, input string tag,
                       input step_t s, input bit r);
    logic [18:0] e;
    logic [3:0]  es;
    e  = exp_vec(s, op[d], en[d], r);
    es = s.st[3:0];
    total++;
    assert (st[d] === es) else begin
      bad++;
      $error("FAIL %s dut%0d: state got %0d want %0d", tag, d, st[d], es);
    end
    total++;
    assert (ov[d] === e) else begin
      bad++;
      $error("FAIL %s dut%0d: outs got %b want %b (state %0d)",
             tag, d, ov[d], e, es);
    end
  endtask

  task automatic pulse_reset(input int d, input string tag);
    step_t f;
    f.st = 0; f.last = 1; f.und = 0;
    en[d]  = 1'b1;
    rst[d] = 1'b1;
    #1 check(d, {tag, "_rst_async"}, f, 1);
    @(posedge clk);
    @(negedge clk);
    #1 check(d, {tag, "_rst_held"}, f, 1);
    rst[d] = 1'b0;
    en[d]  = 1'b0;
  endtask

  // mode 0: random enable, 1: enable high, 2: freeze 4 cycles in MEM_READ
  task automatic run(input int d, input logic [5:0] o, input bit v,
                     input bit a, input int mode, input int stop_st,
                     input string tag);
    int n   = 0;
    int frz = 4;
    q.delete();
    build(d, o, v, a);
    op[d] = o; ovf[d] = v; aund[d] = a;
    while (q.size() > 0) begin
      if (stop_st >= 0 && q[0].st == stop_st) begin
        pulse_reset(d, tag);
        return;
      end
      if (n++ > 300) begin
        total++;
        bad++;
        $error("FAIL %s dut%0d: timeout got %0d cycles want <=300",
               tag, d, n);
        return;
      end
      case (mode)
        0: en[d] = ($urandom_range(3) != 0);
        2: if (q[0].st == 3 && frz > 0) begin
             en[d] = 1'b0;
             frz--;
           end else en[d] = 1'b1;
        default: en[d] = 1'b1;
      endcase
      #1 check(d, tag, q[0], 0);
      @(posedge clk);
      if (en[d]) void'(q.pop_front());
      @(negedge clk);
      en[d] = 1'b0;
    end
  endtask

  initial begin
    logic [5:0] tbl[8];
    tbl = '{LW, SW, RT, BEQ, BNE, JMP, ADDI, 6'h3f};
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; ovf[i] = 1'b0;
      aund[i] = 1'b0; op[i] = 6'd0;
    end
    repeat (2) @(negedge clk);
    pulse_reset(0, "init");
    pulse_reset(1, "init");

    run(0, LW,   0, 0, 1, -1, "lw_ws0");
    run(1, SW,   0, 0, 1, -1, "sw_ws2");
    run(1, LW,   0, 0, 1, -1, "lw_ws2");
    run(0, BNE,  0, 0, 1, -1, "bne");
    run(0, BEQ,  0, 0, 1, -1, "beq");
    run(0, JMP,  0, 0, 1, -1, "jump");
    run(0, RT,   0, 0, 1, -1, "rtype");
    run(0, ADDI, 1, 0, 1, -1, "addi_ovf");
    run(0, 6'h3f, 0, 0, 1, -1, "undef_op");
    run(0, RT,   0, 1, 1, -1, "r_aluundef");
    run(0, RT,   1, 0, 1, -1, "r_ovf");
    run(0, LW,   0, 0, 2, -1, "freeze_memrd");
    run(1, SW,   0, 0, 2, -1, "sw_nofreeze");
    run(0, RT,   0, 0, 1, 6,  "rst_rexec");
    run(0, RT,   0, 0, 1, -1, "after_rst");
    run(1, LW,   0, 0, 1, 3,  "rst_wait");
    run(1, SW,   0, 0, 1, -1, "after_rst2");

    for (int i = 0; i < 80; i++) begin
      int d;
      int k;
      logic [5:0] o;
      d = $urandom_range(1);
      k = $urandom_range(7);
      o = (k == 7) ? 6'($urandom) : tbl[k];
      run(d, o, 1'($urandom), 1'($urandom), 0, -1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter: WAIT_STATES, default 0, extra memory-wait cycles (0..7) added to FETCH, MEM_READ and MEM_WRITE.
REQ-002 clk  in  1  system clock, rising-edge active.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 enable  in  1  global advance qualifier; low freezes the block.
REQ-005 opcode  in  6  instruction-register bits [31:26].
REQ-006 overflow  in  1  ALU signed-overflow flag.
REQ-007 alu_undefined_instr  in  1  ALU control reports an unknown funct.
REQ-008 pc_write, pc_write_cond_eq, pc_write_cond_ne, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a  out  1 each  datapath strobes and selects.
REQ-009 alu_src_b  out  2  ALU operand B select: 00 reg B, 01 const 4, 10 sign-extended immediate, 11 immediate shifted left 2.
REQ-010 alu_op  out  2  00 add, 01 subtract, 10 funct-decoded.
REQ-011 pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector.
REQ-012 write_epc  out  1  EPC capture strobe.
REQ-013 undefined_instr  out  1  exception-cause flag.
REQ-014 state  out  4  current state encoding, for debug.

Function
REQ-015 The block SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, EXC=12.
REQ-016 FETCH: mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_write=1, pc_source=00; next state DECODE.
REQ-017 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode: 100011/101011->MEM_ADDR, 000000->R_EXEC, 000100/000101->BRANCH, 000010->JUMP, 001000->ADDI_EXEC, any other->EXC (per REQ-031/032).
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEM_READ for lw, MEM_WRITE for sw.
REQ-019 MEM_READ: mem_read=1, iord=1; next state MEM_WB. MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; next state FETCH.
REQ-020 MEM_WRITE: mem_write=1, iord=1; next state FETCH.
REQ-021 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next state R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond_eq=1 for opcode 000100 or pc_write_cond_ne=1 for 000101; next state FETCH.
REQ-023 JUMP: pc_write=1, pc_source=10; next state FETCH.
REQ-024 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; next state ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
REQ-025 Every output not listed for a state SHALL be 0.
REQ-026 A 3-bit wait counter SHALL hold FETCH, MEM_READ and MEM_WRITE for WAIT_STATES+1 cycles with all selects and mem_read/mem_write held stable; ir_write and pc_write in FETCH SHALL assert only in the final cycle; the counter SHALL clear on every state exit.
REQ-027 With enable=0, state and wait counter SHALL hold, and pc_write, pc_write_cond_eq, pc_write_cond_ne, ir_write, reg_write, mem_write, write_epc SHALL be forced 0.
REQ-028 opcode SHALL be consumed only in DECODE, MEM_ADDR and BRANCH; it is stable from the instruction register after FETCH.

Reset
REQ-029 reset=1 SHALL immediately force state=FETCH and wait counter=0, independent of clk, including mid-instruction or mid-wait.
REQ-030 While reset=1 all write strobes SHALL be 0; after release the first rising edge SHALL be FETCH cycle 0.

Configuration
REQ-031 Macro MC_CTRL_EXCEPTION_EN defined: undefined opcode in DECODE, overflow=1 in R_EXEC/ADDI_EXEC, or alu_undefined_instr=1 in R_EXEC SHALL go to EXC in place of the normal successor (suppressing writeback); EXC drives write_epc=1, pc_write=1, pc_source=11, undefined_instr=1 except for overflow cause (0), then goes to FETCH.
REQ-032 Macro undefined: EXC is unreachable; undefined opcodes go DECODE->FETCH as NOP; overflow and alu_undefined_instr are ignored; write_epc and undefined_instr are tied 0.

Verification
REQ-033 WAIT_STATES=0, lw (100011) -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4.
REQ-034 WAIT_STATES=2, sw (101011) -> FETCH lasts 3 cycles with ir_write=1 only in the 3rd; MEM_WRITE lasts 3 cycles with mem_write=1 throughout.
REQ-035 bne (000101) -> 0,1,8,0; pc_write_cond_ne=1, pc_write_cond_eq=0, pc_source=01 in state 8.
REQ-036 Macro defined, addi with overflow=1 in ADDI_EXEC -> state 12 next, write_epc=1, pc_source=11, undefined_instr=0, no reg_write; opcode 111111 -> EXC with undefined_instr=1; macro undefined -> back to FETCH.
REQ-037 enable=0 for 4 cycles in MEM_READ -> state frozen, strobes 0; reset pulsed mid-R_EXEC -> state=0 asynchronously, no reg_write issued.
